// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, NOP word, reset PC.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_if.sv
// Fetch unit bus: pipeline control, instruction-memory handshake and decode-side outputs.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned N = XLEN
);
  logic         stall;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ready;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] PC_4;
  logic [N-1:0] Instruction;
  logic         fetch_valid;

  // Fetch unit side
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, PC_4, Instruction, fetch_valid
  );

  // Pipeline / memory side
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, PC_4, Instruction, fetch_valid
  );
endinterface : if_fetch_unit_if

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, negedge-clocked load.
module pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned   N        = XLEN,
  parameter logic [N-1:0]  RESET_PC = N'(RESET_PC_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_en_i,
  input  logic [N-1:0] ld_val_i,
  output logic [N-1:0] pc_o
);

  logic [N-1:0] pc_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (ld_en_i) begin
      pc_q <= ld_val_i;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_reg

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with a one-entry hold buffer for decode stalls.
// Optional macro IF_FETCH_FLUSH_EN: a redirect also squashes the presented instruction.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned  N        = XLEN,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_unit_if.master   bus
);

  fetch_state_e state_q, state_d;

  logic [N-1:0] pc;
  logic [N-1:0] pc_plus4;
  logic         pc_ld_en;
  logic [N-1:0] pc_ld_val;

  logic [N-1:0] hold_instr_q, hold_instr_d;
  logic [N-1:0] hold_pc4_q,   hold_pc4_d;
  logic [N-1:0] instr_q,      instr_d;
  logic [N-1:0] pc4_q,        pc4_d;
  logic         valid_q,      valid_d;

  // Redirect targets are forced word-aligned; the dropped offset bits are intentionally ignored
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign pc_plus4 = pc + N'(4);

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .ld_en_i  (pc_ld_en),
    .ld_val_i (pc_ld_val),
    .pc_o     (pc)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      instr_q      <= N'(NOP);
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state: redirect wins over stall and memory completion
  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    pc_ld_en     = 1'b0;
    pc_ld_val    = pc_plus4;

    if (bus.redirect_valid) begin
      pc_ld_en     = 1'b1;
      pc_ld_val    = {bus.redirect_pc[N-1:2], 2'b00};
      state_d      = FETCH;
      hold_instr_d = '0;
      hold_pc4_d   = '0;
`ifdef IF_FETCH_FLUSH_EN
      instr_d      = N'(NOP);
      valid_d      = 1'b0;
`endif
    end else begin
      unique case (state_q)
        FETCH: begin
          if (bus.imem_ready) begin
            pc_ld_en = 1'b1;
            if (bus.stall) begin
              hold_instr_d = bus.imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = HOLD;
            end else begin
              instr_d = bus.imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!bus.stall) begin
            instr_d = N'(NOP);
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            instr_d = hold_instr_q;
            pc4_d   = hold_pc4_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.Instruction = instr_q;
  assign bus.PC_4        = pc4_q;
  assign bus.fetch_valid = valid_q;

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; state updates on negedge, checks 2 time units later.
module tb_if_fetch_unit;

  logic clk;
  logic reset;
  int unsigned vectors;
  int unsigned miscompares;

  if_fetch_unit_if #(.N(32)) bus ();

  if_fetch_unit #(
    .N        (32),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid);
    chk({tag, ".instr"}, bus.Instruction, instr);
    chk({tag, ".pc4"},   bus.PC_4,        pc4);
    chk({tag, ".valid"}, 32'(bus.fetch_valid), 32'(valid));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ready     = 1'b0;
    bus.imem_rdata     = '0;

    // Reset state
    tick();
    chk_out("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.addr", bus.imem_addr, 32'h0040_0000);
    reset = 1'b1;
    #1;
    chk("rel.req", 32'(bus.imem_req), 32'd1);

    // Streaming fetch
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hA000_0000;
    chk("s0.addr", bus.imem_addr, 32'h0040_0000);
    tick();
    chk_out("s0", 32'hA000_0000, 32'h0040_0004, 1'b1);
    chk("s1.addr", bus.imem_addr, 32'h0040_0004);
    bus.imem_rdata = 32'hA000_0001;
    tick();
    chk_out("s1", 32'hA000_0001, 32'h0040_0008, 1'b1);
    chk("s2.addr", bus.imem_addr, 32'h0040_0008);
    bus.imem_rdata = 32'hA000_0002;
    tick();
    chk_out("s2", 32'hA000_0002, 32'h0040_000C, 1'b1);

    // Stall with memory completion: capture into hold buffer, outputs frozen
    bus.stall      = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    tick();
    chk_out("h0", 32'hA000_0002, 32'h0040_000C, 1'b1);
    chk("h0.req",  32'(bus.imem_req), 32'd0);
    chk("h0.addr", bus.imem_addr, 32'h0040_0010);
    bus.imem_rdata = 32'hBAD0_0000;
    for (int i = 1; i < 3; i++) begin
      tick();
      chk_out("h1", 32'hA000_0002, 32'h0040_000C, 1'b1);
      chk("h1.req", 32'(bus.imem_req), 32'd0);
    end
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b0;
    tick();
    chk_out("hrel", 32'h2008_0005, 32'h0040_0010, 1'b1);
    chk("hrel.req", 32'(bus.imem_req), 32'd1);

    // Memory not ready: bubbles, PC constant
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("nr", 32'h0, 32'h0040_0010, 1'b0);
      chk("nr.addr", bus.imem_addr, 32'h0040_0010);
    end

    // Normal fetch then redirect coincident with stall and ready
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h3333_3333;
    tick();
    chk_out("pre", 32'h3333_3333, 32'h0040_0014, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0103;
    bus.stall          = 1'b1;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    tick();
`ifdef IF_FETCH_FLUSH_EN
    chk_out("rd", 32'h0, 32'h0040_0014, 1'b0);
`else
    chk_out("rd", 32'h3333_3333, 32'h0040_0014, 1'b1);
`endif
    chk("rd.addr", bus.imem_addr, 32'h0040_0100);
    chk("rd.req",  32'(bus.imem_req), 32'd1);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    bus.imem_rdata     = 32'h4444_4444;
    tick();
    chk_out("rdn", 32'h4444_4444, 32'h0040_0104, 1'b1);

    // Redirect during HOLD discards buffer; wrap from 0xFFFFFFFC
    bus.stall      = 1'b1;
    bus.imem_rdata = 32'h5555_5555;
    tick();
    chk("wh.req", 32'(bus.imem_req), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
`ifdef IF_FETCH_FLUSH_EN
    chk_out("wr", 32'h0, 32'h0040_0104, 1'b0);
`else
    chk_out("wr", 32'h4444_4444, 32'h0040_0104, 1'b1);
`endif
    chk("wr.addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr.req",  32'(bus.imem_req), 32'd1);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    bus.imem_rdata     = 32'h6666_6666;
    tick();
    chk_out("wrap", 32'h6666_6666, 32'h0000_0000, 1'b1);
    chk("wrap.addr", bus.imem_addr, 32'h0000_0000);

    // Asynchronous reset between edges while in HOLD
    bus.stall      = 1'b1;
    bus.imem_rdata = 32'h7777_7777;
    tick();
    chk("ar.hold", 32'(bus.imem_req), 32'd0);
    #3;
    reset = 1'b0;
    #1;
    chk_out("ar", 32'h0, 32'h0, 1'b0);
    chk("ar.addr", bus.imem_addr, 32'h0040_0000);
    chk("ar.req",  32'(bus.imem_req), 32'd1);
    #1;
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.imem_rdata = 32'h8888_8888;
    tick();
    chk_out("arr", 32'h8888_8888, 32'h0040_0004, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_if_fetch_unit
